// File: rtl/shift_seq_if.sv
// Operand/result bundle between the control unit and the multicycle shifter.
// The master (control unit) drives start/ALUfun/B/shamt; the slave (shift_seq) drives busy/done/y/dbg_state.
interface shift_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       ALUfun;
   logic [WIDTH-1:0] B;
   logic [4:0]       shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;
   logic [1:0]       dbg_state;

   modport master (
      output start, ALUfun, B, shamt,
      input  busy, done, y, dbg_state
   );

   modport slave (
      input  start, ALUfun, B, shamt,
      output busy, done, y, dbg_state
   );
endinterface

// File: rtl/shift_seq.sv
// Multicycle shifter: moves y by up to STEP bits per clock using the ALUfun shift encoding.
// Define SHIFT_SEQ_ROR_EN to make ALUfun=10 rotate right instead of SRA.
module shift_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 2
) (
   input  logic       clk,
   input  logic       reset,
   shift_seq_if.slave bus
);
   // Handshake: start is taken only while not in SHIFT (IDLE or DONE); busy is high
   // exactly in SHIFT, done pulses for the single DONE cycle, and y is final from DONE
   // until the next accepted start.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [4:0] STEP_W = 5'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [4:0]       rem_q, rem_d;
   logic [1:0]       mode_q, mode_d;

   logic [4:0]              k;
   logic signed [WIDTH-1:0] y_s;
   logic [WIDTH-1:0]        shifted;

   assign y_s = y_q;

   always_comb begin
      k = (rem_q < STEP_W) ? rem_q : STEP_W;
      shifted = y_q;
      case (mode_q)
         2'b00: shifted = y_q << k;
         2'b01: shifted = y_q >> k;
`ifdef SHIFT_SEQ_ROR_EN
         // k is never zero in SHIFT, so the left term never shifts by WIDTH
         2'b10: shifted = (y_q >> k) | (y_q << (6'(WIDTH) - {1'b0, k}));
`else
         2'b10: shifted = y_s >>> k;
`endif
         default: shifted = y_s >>> k;
      endcase
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      case (state_q)
         ST_SHIFT: begin
            y_d   = shifted;
            rem_d = rem_q - k;
            if (rem_q <= STEP_W) state_d = ST_DONE;
         end
         default: begin
            if (bus.start) begin
               y_d     = bus.B;
               mode_d  = bus.ALUfun;
               rem_d   = bus.shamt;
               state_d = (bus.shamt != 5'd0) ? ST_SHIFT : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
         rem_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.busy      = (state_q == ST_SHIFT);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.y         = y_q;
   assign bus.dbg_state = state_q;
endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle variable-amount shifter for the ALU shift path.
- Moves a 32-bit operand by a 5-bit amount at STEP bit positions per clock, instead of a full combinational barrel.
- Intended for area-reduced or multicycle builds of the MIPS core.
- Uses the same ALUfun shift encoding as the combinational shifter stages and a start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 32: operand and result width.
- STEP, 2: bit positions shifted per SHIFT cycle. Legal values are 1, 2, 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- ALUfun  input  2  00=SLL, 01=SRL, 1x=SRA.
- B  input  WIDTH  operand; latched on accepted start.
- shamt  input  5  shift amount 0..31; latched on accepted start.
- busy  output  1  high while shifting (state SHIFT).
- done  output  1  one-cycle pulse when the result is final.
- y  output  WIDTH  working/result register.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-low.
- Reset values: state=IDLE, y=0, busy=0, done=0, remaining-count=0, latched mode=00.
- States:
  - IDLE: waiting for start.
  - SHIFT: iterating.
  - DONE: result final for one cycle.
- Acceptance: start is accepted when state is IDLE or DONE. start in SHIFT is ignored and does not disturb the operation in progress.
- On accept:
  - y<=B, mode<=ALUfun, remaining<=shamt.
  - Next state is SHIFT if shamt!=0, else DONE.
- SHIFT, each cycle:
  - k = min(STEP, remaining).
  - y is shifted by k per the latched mode.
  - remaining <= remaining-k.
  - If remaining<=STEP, the next state is DONE.
- Shift arithmetic:
  - SLL fills with 0 from the LSB.
  - SRL fills with 0 from the MSB.
  - SRA fills with the current y[WIDTH-1], i.e. the original sign.
- DONE: done=1 and busy=0 for exactly one cycle. Next state is SHIFT/DONE if start is accepted that cycle, else IDLE.
- Latency: with start high in cycle 0, busy=1 in cycles 1..N and done=1 in cycle N+1, where N=ceil(shamt/STEP). shamt=0 gives done in cycle 1 with y=B.
- Output stability: y holds its value from DONE until the next accepted start. Intermediate y values while busy=1 are not valid results.
- Mode and operand independence: mode, B and shamt changing after acceptance have no effect.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. No done pulse is generated.
- Back-to-back: start in the DONE cycle begins a new operation with no idle bubble; done drops the next cycle.

Optional Feature:
- Macro: SHIFT_SEQ_ROR_EN.
- Defined: ALUfun=10 selects rotate-right. Bits leaving the LSB re-enter at the MSB; ALUfun=11 remains SRA.
- Undefined: ALUfun=10 and 11 are both SRA, and no rotate logic is synthesized.

Test Plan:
- SLL, B=0x00000001, shamt=31, STEP=2, start in cycle 0 -> busy cycles 1..16, done in cycle 17, y=0x80000000.
- SRA (ALUfun=11), B=0x80000000, shamt=4 -> done in cycle 3, y=0xF8000000. SRL (01), B=0xF000000F, shamt=5 -> done in cycle 4, y=0x07800000.
- shamt=0, ALUfun=00, B=0x12345678 -> busy never high, done in cycle 1, y=0x12345678.
- start pulsed with new B during SHIFT -> ignored, original result produced. start held during the DONE cycle with B=0xFFFFFFFF, shamt=1, ALUfun=01 -> next result y=0x7FFFFFFF with no IDLE cycle.
- reset asserted in cycle 2 of a shamt=20 SLL -> busy=0, done=0, y=0 immediately. A start after release completes normally.
- ALUfun=10, B=0x00000003, shamt=1 -> y=0x80000001 with SHIFT_SEQ_ROR_EN, y=0x00000001 without.
